// File: rtl/quick_spi_scheduler_pkg.sv
// Shared definitions for the quick_spi transaction scheduler.
//   - default parameter values
//   - scheduler state encoding (3-bit)
//   - clog2_min1: ceiling log2 with a floor of 1, used to size index and
//     watchdog registers
package quick_spi_scheduler_pkg;

   localparam int unsigned DEF_NUM_REQ        = 4;
   localparam int unsigned DEF_SLAVE_WIDTH    = 2;
   localparam int unsigned DEF_OUT_WIDTH      = 16;
   localparam int unsigned DEF_IN_WIDTH       = 8;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } sched_state_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/quick_spi_rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req       in   NUM_REQ  request vector
//   start_idx in   ID_W     first index searched (highest priority)
//   found     out  1        at least one request present
//   winner    out  ID_W     first requesting index at or after start_idx
module quick_spi_rr_arbiter
   import quick_spi_scheduler_pkg::*;
#(
   parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
   localparam int unsigned ID_W    = clog2_min1(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    start_idx,
   output logic               found,
   output logic [ID_W-1:0]    winner
);

   logic [31:0] idx;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(start_idx) + i) % NUM_REQ;
         if (!found && req[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/quick_spi_scheduler.sv
// Round-robin scheduler sharing one quick_spi master among NUM_REQ clients.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/operation/slave/wdata   per-requester request and payload
//   req_done, rsp_data, rsp_error     one-hot completion pulse and response
//   busy, grant_id              scheduler status
//   spi_*                       connection to the quick_spi master
// All outputs are registered from the state being left at each edge, so
// the spi_start pulse appears in the cycle after the ISSUE state.
module quick_spi_scheduler
   import quick_spi_scheduler_pkg::*;
#(
   parameter  int unsigned NUM_REQ        = DEF_NUM_REQ,
   parameter  int unsigned SLAVE_WIDTH    = DEF_SLAVE_WIDTH,
   parameter  int unsigned OUT_WIDTH      = DEF_OUT_WIDTH,
   parameter  int unsigned IN_WIDTH       = DEF_IN_WIDTH,
   parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int unsigned ID_W           = clog2_min1(NUM_REQ)
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_operation,
   input  logic [NUM_REQ*SLAVE_WIDTH-1:0] req_slave,
   input  logic [NUM_REQ*OUT_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             req_done,
   output logic [IN_WIDTH-1:0]            rsp_data,
   output logic                           rsp_error,
   output logic                           busy,
   output logic [ID_W-1:0]                grant_id,
   output logic                           spi_enable,
   output logic                           spi_start,
   output logic [SLAVE_WIDTH-1:0]         spi_slave,
   output logic                           spi_operation,
   output logic [OUT_WIDTH-1:0]           spi_outgoing_data,
   input  logic                           spi_end_of_transaction,
   input  logic [IN_WIDTH-1:0]            spi_incoming_data
);

   localparam int unsigned WD_W = clog2_min1(TIMEOUT_CYCLES);

   sched_state_t           state, state_next;
   // rr_ptr holds the highest-priority index, i.e. one past the last grant;
   // its reset value 0 therefore gives requester 0 first priority.
   logic [ID_W-1:0]        rr_ptr;
   logic [ID_W-1:0]        ptr_after_grant;
   logic [WD_W-1:0]        watchdog;
   logic                   wd_expired;
   logic                   arb_found;
   logic [ID_W-1:0]        arb_winner;
   logic                   sel_op;
   logic [SLAVE_WIDTH-1:0] sel_slave;
   logic [OUT_WIDTH-1:0]   sel_wdata;
   logic [NUM_REQ-1:0]     grant_onehot;

   quick_spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .start_idx (rr_ptr),
      .found     (arb_found),
      .winner    (arb_winner)
   );

   always_comb begin
      sel_op       = 1'b0;
      sel_slave    = '0;
      sel_wdata    = '0;
      grant_onehot = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_winner == ID_W'(i)) begin
            sel_op    = req_operation[i];
            sel_slave = req_slave[i*SLAVE_WIDTH +: SLAVE_WIDTH];
            sel_wdata = req_wdata[i*OUT_WIDTH +: OUT_WIDTH];
         end
         if (grant_id == ID_W'(i)) grant_onehot[i] = 1'b1;
      end
   end

   assign ptr_after_grant = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
   assign wd_expired      = (watchdog == WD_W'(TIMEOUT_CYCLES-1));

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (arb_found) state_next = ST_ISSUE;
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT: begin
            // completion takes precedence over an expiring watchdog
            if (spi_end_of_transaction) state_next = ST_DONE;
            else if (wd_expired)        state_next = ST_ABORT;
         end
         ST_DONE:  state_next = ST_IDLE;
         ST_ABORT: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_IDLE;
         rr_ptr            <= '0;
         watchdog          <= '0;
         req_done          <= '0;
         rsp_data          <= '0;
         rsp_error         <= 1'b0;
         busy              <= 1'b0;
         grant_id          <= '0;
         spi_enable        <= 1'b0;
         spi_start         <= 1'b0;
         spi_slave         <= '0;
         spi_operation     <= 1'b0;
         spi_outgoing_data <= '0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != ST_IDLE);
         req_done   <= '0;
         spi_start  <= 1'b0;
         spi_enable <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  grant_id          <= arb_winner;
                  spi_operation     <= sel_op;
                  spi_slave         <= sel_slave;
                  spi_outgoing_data <= sel_wdata;
               end
            end
            ST_ISSUE: begin
               spi_enable <= 1'b1;
               spi_start  <= 1'b1;
               watchdog   <= '0;
            end
            ST_WAIT: begin
               spi_enable <= 1'b1;
               watchdog   <= watchdog + 1'b1;
               if (spi_end_of_transaction) rsp_data <= spi_incoming_data;
            end
            ST_DONE: begin
               req_done  <= grant_onehot;
               rsp_error <= 1'b0;
               rr_ptr    <= ptr_after_grant;
            end
            ST_ABORT: begin
               req_done  <= grant_onehot;
               rsp_error <= 1'b1;
               rsp_data  <= '0;
               rr_ptr    <= ptr_after_grant;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_quick_spi_scheduler.sv
`timescale 1ns/1ps
module tb_quick_spi_scheduler;

   localparam int unsigned N   = 4;
   localparam int unsigned SW  = 2;
   localparam int unsigned OW  = 16;
   localparam int unsigned IW  = 8;
   localparam int unsigned IDW = 2;
   localparam int unsigned TO  = 48;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_operation = '0;
   logic [N*SW-1:0] req_slave = '0;
   logic [N*OW-1:0] req_wdata = '0;
   logic [N-1:0]    req_done;
   logic [IW-1:0]   rsp_data;
   logic            rsp_error;
   logic            busy;
   logic [IDW-1:0]  grant_id;
   logic            spi_enable;
   logic            spi_start;
   logic [SW-1:0]   spi_slave;
   logic            spi_operation;
   logic [OW-1:0]   spi_outgoing_data;
   logic            spi_eot;
   logic [IW-1:0]   spi_incoming_data;

   logic            resp_eot = 1'b0;
   logic            stray_eot = 1'b0;
   logic [IW-1:0]   resp_rdata = '0;
   int              resp_delay = 0;
   int              resp_cnt = 0;

   int n_vec = 0;
   int n_bad = 0;
   int n_start = 0;
   int n_done = 0;
   int n_en = 0;

   assign spi_eot           = resp_eot | stray_eot;
   assign spi_incoming_data = spi_eot ? resp_rdata : ~resp_rdata;

   always #5 clk = ~clk;

   quick_spi_scheduler #(
      .NUM_REQ        (N),
      .SLAVE_WIDTH    (SW),
      .OUT_WIDTH      (OW),
      .IN_WIDTH       (IW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .req_valid              (req_valid),
      .req_operation          (req_operation),
      .req_slave              (req_slave),
      .req_wdata              (req_wdata),
      .req_done               (req_done),
      .rsp_data               (rsp_data),
      .rsp_error              (rsp_error),
      .busy                   (busy),
      .grant_id               (grant_id),
      .spi_enable             (spi_enable),
      .spi_start              (spi_start),
      .spi_slave              (spi_slave),
      .spi_operation          (spi_operation),
      .spi_outgoing_data      (spi_outgoing_data),
      .spi_end_of_transaction (spi_eot),
      .spi_incoming_data      (spi_incoming_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // quick_spi stand-in: end_of_transaction resp_delay cycles after start (0 = never)
   always @(negedge clk) begin
      resp_eot = 1'b0;
      if (spi_start === 1'b1) resp_cnt = resp_delay;
      else if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) resp_eot = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (spi_start === 1'b1)  n_start++;
      if (spi_enable === 1'b1) n_en++;
      if (req_done !== '0)     n_done++;
   end

   // Transaction-level model: m_age counts edges since the grant edge.
   // age 1 -> start pulse, then WAIT edges j = age-1 until eot or j == TO,
   // then one edge later the completion pulse.
   bit             m_act = 1'b0;
   bit             m_ended = 1'b0;
   bit             m_err = 1'b0;
   int             m_age = 0;
   int             m_id = 0;
   int             m_ptr = 0;
   int             m_idx = 0;
   logic [N-1:0]   e_done = '0;
   logic [IW-1:0]  e_data = '0;
   logic           e_err = 1'b0;
   logic           e_busy = 1'b0;
   logic           e_en = 1'b0;
   logic           e_start = 1'b0;
   logic [IDW-1:0] e_grant = '0;
   logic [SW-1:0]  e_slave = '0;
   logic           e_op = 1'b0;
   logic [OW-1:0]  e_wdata = '0;

   always @(posedge clk) begin
      e_start = 1'b0;
      e_done  = '0;
      if (reset) begin
         m_act = 1'b0; m_ptr = 0;
         e_data = '0; e_err = 1'b0; e_busy = 1'b0; e_en = 1'b0;
         e_grant = '0; e_slave = '0; e_op = 1'b0; e_wdata = '0;
      end else if (!m_act) begin
         e_busy = 1'b0;
         e_en   = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_idx = (m_ptr + i) % N;
            if (!m_act && req_valid[m_idx]) begin
               m_act = 1'b1;
               m_id  = m_idx;
            end
         end
         if (m_act) begin
            m_age = 0; m_ended = 1'b0; m_err = 1'b0;
            e_busy  = 1'b1;
            e_grant = m_id[IDW-1:0];
            e_op    = req_operation[m_id];
            e_slave = req_slave[m_id*SW +: SW];
            e_wdata = req_wdata[m_id*OW +: OW];
         end
      end else begin
         m_age++;
         if (m_age == 1) begin
            e_start = 1'b1;
            e_en    = 1'b1;
         end else if (!m_ended) begin
            e_en = 1'b1;
            if (spi_eot) begin
               m_ended = 1'b1;
               e_data  = spi_incoming_data;
            end else if (m_age - 1 == TO) begin
               m_ended = 1'b1;
               m_err   = 1'b1;
            end
         end else begin
            e_en   = 1'b0;
            e_busy = 1'b0;
            e_done[m_id] = 1'b1;
            e_err  = m_err;
            if (m_err) e_data = '0;
            m_ptr = (m_id + 1) % N;
            m_act = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy",          64'(busy),              64'(e_busy));
      chk("grant_id",      64'(grant_id),          64'(e_grant));
      chk("spi_enable",    64'(spi_enable),        64'(e_en));
      chk("spi_start",     64'(spi_start),         64'(e_start));
      chk("spi_slave",     64'(spi_slave),         64'(e_slave));
      chk("spi_operation", 64'(spi_operation),     64'(e_op));
      chk("spi_out_data",  64'(spi_outgoing_data), 64'(e_wdata));
      chk("req_done",      64'(req_done),          64'(e_done));
      chk("rsp_error",     64'(rsp_error),         64'(e_err));
      chk("rsp_data",      64'(rsp_data),          64'(e_data));
   end

   task automatic wait_done(input int max, output logic [N-1:0] d);
      int n;
      n = 0;
      d = '0;
      while (n < max && d == '0) begin
         tick();
         n++;
         if (req_done !== '0) d = req_done;
      end
      if (d == '0) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_done: no req_done within %0d cycles", max);
      end
   endtask

   task automatic wait_start(input int max);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (n < max && !seen) begin
         tick();
         n++;
         if (spi_start === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_start: no spi_start within %0d cycles", max);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [N-1:0] d;
      logic [N-1:0] exp_seq [8];
      int s0, e0, d0;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

      repeat (3) tick();
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(req_done), 64'(0));
      reset = 1'b0;
      tick();

      // single request from requester 2
      req_slave[2*SW +: SW] = 2'b01;
      req_operation[2]      = 1'b1;
      req_wdata[2*OW +: OW] = 16'h5A6A;
      resp_rdata = 8'h95;
      resp_delay = 40;
      s0 = n_start; e0 = n_en;
      req_valid = 4'b0100;
      wait_done(200, d);
      chk("t1_done",    64'(d),            64'(4'b0100));
      chk("t1_data",    64'(rsp_data),     64'(8'h95));
      chk("t1_err",     64'(rsp_error),    64'(0));
      chk("t1_starts",  64'(n_start - s0), 64'(1));
      chk("t1_slave",   64'(spi_slave),    64'(2'b01));
      chk("t1_wdata",   64'(spi_outgoing_data), 64'(16'h5A6A));
      chk("t1_en_cyc",  64'(n_en - e0),    64'(42));
      req_valid = '0;

      // two simultaneous requests: pointer is past 2, so 0 then 1
      req_slave[0*SW +: SW] = 2'b10; req_wdata[0*OW +: OW] = 16'h1111;
      req_slave[1*SW +: SW] = 2'b11; req_wdata[1*OW +: OW] = 16'h2222;
      resp_rdata = 8'hA7;
      resp_delay = 5;
      req_valid = 4'b0011;
      wait_done(100, d);
      chk("t2_first", 64'(d), 64'(4'b0001));
      req_valid[0] = 1'b0;
      wait_done(100, d);
      chk("t2_second", 64'(d), 64'(4'b0010));
      req_valid = '0;

      // all four held after a reset: strict rotation from 0
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      req_slave[3*SW +: SW] = 2'b00; req_wdata[3*OW +: OW] = 16'hC0DE;
      resp_delay = 3;
      req_valid = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         wait_done(100, d);
         chk("t3_seq", 64'(d), 64'(exp_seq[t]));
      end
      req_valid = '0;

      // timeout abort: no end_of_transaction ever
      resp_delay = 0;
      e0 = n_en;
      req_valid = 4'b0010;
      wait_done(200, d);
      chk("t4_done",   64'(d),          64'(4'b0010));
      chk("t4_err",    64'(rsp_error),  64'(1));
      chk("t4_data",   64'(rsp_data),   64'(0));
      chk("t4_busy",   64'(busy),       64'(0));
      chk("t4_en",     64'(spi_enable), 64'(0));
      chk("t4_en_cyc", 64'(n_en - e0),  64'(TO + 1));
      req_valid = '0;

      // end_of_transaction exactly on the expiry cycle: success wins
      resp_delay = TO - 1;
      resp_rdata = 8'h3C;
      req_valid = 4'b1000;
      wait_done(200, d);
      chk("t5_done", 64'(d),         64'(4'b1000));
      chk("t5_err",  64'(rsp_error), 64'(0));
      chk("t5_data", 64'(rsp_data),  64'(8'h3C));
      req_valid = '0;

      // reset mid-WAIT drops the transaction without a completion pulse
      resp_delay = 0;
      req_valid = 4'b1000;
      wait_start(20);
      repeat (5) tick();
      d0 = n_done;
      reset = 1'b1;
      tick();
      chk("t6_busy",  64'(busy),       64'(0));
      chk("t6_en",    64'(spi_enable), 64'(0));
      chk("t6_grant", 64'(grant_id),   64'(0));
      reset = 1'b0;
      resp_delay = 3;
      wait_start(20);
      chk("t6_regrant", 64'(grant_id), 64'(3));
      wait_done(50, d);
      chk("t6_done",  64'(d),            64'(4'b1000));
      chk("t6_count", 64'(n_done - d0),  64'(1));
      req_valid = '0;

      // stray end_of_transaction while idle
      repeat (3) tick();
      d0 = n_done;
      stray_eot = 1'b1;
      tick();
      stray_eot = 1'b0;
      repeat (5) tick();
      chk("t7_no_done", 64'(n_done - d0), 64'(0));
      chk("t7_busy",    64'(busy),        64'(0));

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
